// File: rtl/abft_tile_ctrl.sv
// Tile sequencer for the ABFT column-checksum accumulator array: clear, feed rows, drain, check.
// Optional ABFT_ERR_CNT_EN builds a saturating failing-tile counter on err_cnt_o.
module abft_tile_ctrl #(
   parameter int unsigned arraySize    = 4,
   parameter int unsigned addressWidth = 3,
   parameter int unsigned memAddrWidth = 8,
   parameter int unsigned zBits        = 12
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [memAddrWidth-1:0]       base_addr_i,
   input  logic [arraySize*zBits-1:0]    chk_in_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          rd_en_o,
   output logic [memAddrWidth-1:0]       rd_addr_o,
   input  logic                          rd_gnt_i,
   output logic                          acc_rst_o,
   output logic                          acc_valid_o,
   input  logic [arraySize*zBits-1:0]    z_bus_i,
   output logic                          err_o,
   output logic [arraySize-1:0]          err_mask_o,
   output logic [7:0]                    err_cnt_o
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain0,
      StDrain1,
      StCheck,
      StDone
   } state_e;

   state_e                     state_q, state_d;
   logic [memAddrWidth-1:0]    base_q, base_d;
   logic [arraySize*zBits-1:0] chk_q, chk_d;
   logic [addressWidth-1:0]    cnt_q, cnt_d;
   logic [memAddrWidth-1:0]    addr_hold_q, addr_hold_d;
   logic                       acc_valid_q, acc_valid_d;
   logic                       err_q, err_d;
   logic [arraySize-1:0]       err_mask_q, err_mask_d;
   logic [arraySize-1:0]       mismatch;
   logic [memAddrWidth-1:0]    feed_addr;

   // Row address wraps naturally at memAddrWidth bits.
   assign feed_addr = base_q + memAddrWidth'(cnt_q);

   always_comb begin
      mismatch = '0;
      for (int unsigned k = 0; k < arraySize; k++) begin
         mismatch[k] = (z_bus_i[k*zBits +: zBits] != chk_q[k*zBits +: zBits]);
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      chk_d       = chk_q;
      cnt_d       = cnt_q;
      addr_hold_d = addr_hold_q;
      err_d       = err_q;
      err_mask_d  = err_mask_q;
      busy_o      = (state_q != StIdle);
      done_o      = 1'b0;
      rd_en_o     = 1'b0;
      acc_rst_o   = 1'b0;
      rd_addr_o   = addr_hold_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               base_d     = base_addr_i;
               chk_d      = chk_in_i;
               err_d      = 1'b0;
               err_mask_d = '0;
               state_d    = StClear;
            end
         end
         StClear: begin
            acc_rst_o = 1'b1;
            cnt_d     = '0;
            state_d   = StFeed;
         end
         StFeed: begin
            rd_en_o     = 1'b1;
            rd_addr_o   = feed_addr;
            addr_hold_d = feed_addr;
            if (rd_gnt_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == addressWidth'(arraySize - 1)) begin
                  state_d = StDrain0;
               end
            end
         end
         StDrain0: state_d = StDrain1;
         StDrain1: state_d = StCheck;
         StCheck: begin
            err_mask_d = mismatch;
            err_d      = |mismatch;
            state_d    = StDone;
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      acc_valid_d = rd_en_o & rd_gnt_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         base_q      <= '0;
         chk_q       <= '0;
         cnt_q       <= '0;
         addr_hold_q <= '0;
         acc_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_mask_q  <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         chk_q       <= chk_d;
         cnt_q       <= cnt_d;
         addr_hold_q <= addr_hold_d;
         acc_valid_q <= acc_valid_d;
         err_q       <= err_d;
         err_mask_q  <= err_mask_d;
      end
   end

   assign acc_valid_o = acc_valid_q;
   assign err_o       = err_q;
   assign err_mask_o  = err_mask_q;

`ifdef ABFT_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == StDone) && err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`else
   assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_abft_tile_ctrl.sv
// Scoreboard bench for abft_tile_ctrl; models the row memory and accumulator array around it.
module tb_abft_tile_ctrl;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int ZB = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [AW-1:0]   base_addr;
   logic [N*ZB-1:0] chk_in;
   logic            busy, done, rd_en, rd_gnt, acc_rst, acc_valid, err;
   logic [AW-1:0]   rd_addr;
   logic [N*ZB-1:0] z_bus;
   logic [N-1:0]    err_mask;
   logic [7:0]      err_cnt;

   abft_tile_ctrl #(
      .arraySize    (N),
      .addressWidth (3),
      .memAddrWidth (AW),
      .zBits        (ZB)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .base_addr_i (base_addr),
      .chk_in_i    (chk_in),
      .busy_o      (busy),
      .done_o      (done),
      .rd_en_o     (rd_en),
      .rd_addr_o   (rd_addr),
      .rd_gnt_i    (rd_gnt),
      .acc_rst_o   (acc_rst),
      .acc_valid_o (acc_valid),
      .z_bus_i     (z_bus),
      .err_o       (err),
      .err_mask_o  (err_mask),
      .err_cnt_o   (err_cnt)
   );

   always #5 clk = ~clk;

   // Row memory and accumulator array environment.
   logic [N*ZB-1:0] mem [256];
   logic [N*ZB-1:0] row_q;
   logic [ZB-1:0]   sums [N];

   always @(posedge clk) begin
      if (rd_en && rd_gnt) row_q <= mem[rd_addr];
      if (acc_rst) begin
         for (int k = 0; k < N; k++) sums[k] <= '0;
      end else if (acc_valid) begin
         for (int k = 0; k < N; k++) sums[k] <= sums[k] + row_q[k*ZB +: ZB];
      end
   end

   assign z_bus = {sums[3], sums[2], sums[1], sums[0]};

   typedef struct {
      logic [N-1:0] mask;
      logic         err;
      logic [7:0]   cnt;
   } exp_t;

   exp_t          sb_q[$];
   logic [AW-1:0] addr_q[$];
   int            model_cnt;
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered and left at a negedge; the returning cycle is IDLE, so tiles can run back to back.
   task automatic run_tile(input logic [AW-1:0] base, input bit fixed, input logic [N-1:0] bad,
                           input int stall_at, input int stall_len, input int exp_done,
                           input bit poke);
      logic [ZB-1:0]   s;
      logic [N*ZB-1:0] chk;
      exp_t            e, got_e;
      int              nval, nrst, feed_idx;
      bit              got_done, gnt;
      for (int r = 0; r < N; r++) begin
         if (fixed) mem[AW'(base + AW'(r))] = {12'h004, 12'h008, 12'h00C, 12'h010};
         else       mem[AW'(base + AW'(r))] = {16'($urandom), 32'($urandom)};
         addr_q.push_back(AW'(base + AW'(r)));
      end
      for (int k = 0; k < N; k++) begin
         s = '0;
         for (int r = 0; r < N; r++) s = s + mem[AW'(base + AW'(r))][k*ZB +: ZB];
         chk[k*ZB +: ZB] = bad[k] ? s + 12'd1 : s;
      end
`ifdef ABFT_ERR_CNT_EN
      if (bad != '0 && model_cnt < 255) model_cnt++;
`endif
      e.mask = bad;
      e.err  = |bad;
      e.cnt  = 8'(model_cnt);
      sb_q.push_back(e);
      start     = 1'b1;
      base_addr = base;
      chk_in    = chk;
      nval = 0; nrst = 0; feed_idx = 0; got_done = 0;
      for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
         @(negedge clk);
         start = poke && (cyc == 3);
         if (acc_rst) nrst++;
         if (acc_valid) nval++;
         gnt = 1'b1;
         if (rd_en) begin
            gnt = !(feed_idx >= stall_at && feed_idx < stall_at + stall_len);
            feed_idx++;
            if (gnt) begin
               if (addr_q.size() == 0) check_eq("rd_addr_extra", 1, 0);
               else check_eq("rd_addr", rd_addr, addr_q.pop_front());
            end
         end
         rd_gnt = gnt;
         if (done) begin
            got_done = 1;
            check_eq("done_cycle", cyc, exp_done);
            check_eq("busy_in_done", busy, 1);
            check_eq("rd_addr_hold", rd_addr, AW'(base + AW'(N - 1)));
            got_e = sb_q.pop_front();
            check_eq("err", err, got_e.err);
            check_eq("err_mask", err_mask, got_e.mask);
         end
      end
      check_eq("done_seen", got_done, 1);
      check_eq("acc_valid_pulses", nval, N);
      check_eq("acc_rst_pulses", nrst, 1);
      rd_gnt = 1'b1;
      @(negedge clk);
      check_eq("busy_after_done", busy, 0);
      check_eq("done_one_cycle", done, 0);
      check_eq("err_held", err, e.err);
      check_eq("err_cnt", err_cnt, e.cnt);
   endtask

   initial begin
      int seen;
      rst = 1'b1; start = 1'b0; base_addr = '0; chk_in = '0; rd_gnt = 1'b1;
      model_cnt = 0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_acc_valid", acc_valid, 0);
      check_eq("rst_acc_rst", acc_rst, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_err_mask", err_mask, 0);
      check_eq("rst_rd_addr", rd_addr, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_tile(8'h10, 1, 4'b0000, 99, 0, 9, 0);
      run_tile(8'h10, 1, 4'b0100, 99, 0, 9, 0);
      run_tile(8'h40, 0, 4'b0000, 1, 3, 12, 1);
      run_tile(8'hFE, 0, 4'b1001, 99, 0, 9, 0);

      // Abort a tile mid-FEED with an asynchronous reset.
      start = 1'b1; base_addr = 8'h20;
      @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk);
      check_eq("pre_rst_rd_en", rd_en, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_busy", busy, 0);
      check_eq("arst_rd_en", rd_en, 0);
      check_eq("arst_rd_addr", rd_addr, 0);
      check_eq("arst_err_cnt", err_cnt, 0);
      check_eq("arst_acc_valid", acc_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      model_cnt = 0;
      sb_q.delete();
      addr_q.delete();
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check_eq("no_done_after_rst", seen, 0);

      run_tile(8'h33, 0, 4'b0000, 99, 0, 9, 0);
      for (int t = 0; t < 257; t++) begin
         run_tile(8'($urandom), 0, 4'($urandom_range(1, 15)), 99, 0, 9, 0);
      end
`ifdef ABFT_ERR_CNT_EN
      check_eq("err_cnt_saturated", err_cnt, 255);
`else
      check_eq("err_cnt_absent", err_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
